// File: rtl/ttt_engine_nxn_if.sv
// ttt_engine_nxn_if: move request handshake between a front end and the game engine
interface ttt_engine_nxn_if #(parameter int IW = 2);
  logic          move_valid;
  logic [IW-1:0] move_row;
  logic [IW-1:0] move_col;
  logic          move_ready;
  logic          move_ack;
  logic          move_err;
  modport master (output move_valid, move_row, move_col, input move_ready, move_ack, move_err);
  modport slave (input move_valid, move_row, move_col, output move_ready, move_ack, move_err);
endinterface

// File: rtl/ttt_engine_nxn.sv
// ttt_engine_nxn: N x N, K-in-a-row engine with a 4-cycle directional win scan around the last move
module ttt_engine_nxn #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int IW = ($clog2(N) < 2) ? 2 : $clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_game,
  ttt_engine_nxn_if.slave              mv,
  output logic [2*N*N-1:0]             board,
  output logic [1:0]                   turn,
  output logic [1:0]                   winner,
  output logic                         game_over,
  output logic [$clog2(N*N+1)-1:0]     move_count
);
  localparam int BW = $clog2(2*N*N);
  localparam int MW = $clog2(N*N+1);
  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;
  state_t        state;
  logic [IW-1:0] r_q, c_q;
  logic [1:0]    player, dir;
  logic          win_hit, ack, err, hit, legal;
  int            dr, dc;
  // off-board coordinates read as empty, so a walk stops at the edge
  function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int r, input int c);
    return (r >= 0 && r < N && c >= 0 && c < N) ? b[BW'(2*(r*N+c)) +: 2] : 2'd0;
  endfunction
  function automatic int run_len(input logic [2*N*N-1:0] b, input int r0, input int c0,
                                 input int sr, input int sc, input logic [1:0] p);
    int  n;
    logic go;
    n  = 0;
    go = 1'b1;
    for (int s = 1; s < K; s++) begin
      go = go && (cell_at(b, r0 + s*sr, c0 + s*sc) == p);
      n += int'(go);
    end
    return n;
  endfunction
  always_comb begin
    dr  = (dir == 2'd0) ? 0 : 1;
    dc  = (dir == 2'd1) ? 0 : (dir == 2'd3) ? -1 : 1;
    hit = 1 + run_len(board, int'(r_q), int'(c_q), dr, dc, player)
            + run_len(board, int'(r_q), int'(c_q), -dr, -dc, player) >= K;
  end
  assign legal = int'(mv.move_row) < N && int'(mv.move_col) < N &&
                 cell_at(board, int'(mv.move_row), int'(mv.move_col)) == 2'd0;
  assign mv.move_ready = (state == IDLE) && !game_over;
  assign mv.move_ack   = ack;
  assign mv.move_err   = err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board      <= '0;
      turn       <= 2'd1;
      winner     <= 2'd0;
      game_over  <= 1'b0;
      move_count <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      state      <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      player     <= 2'd0;
      dir        <= 2'd0;
      win_hit    <= 1'b0;
    end else if (new_game) begin
      board      <= '0;
      turn       <= 2'd1;
      winner     <= 2'd0;
      game_over  <= 1'b0;
      move_count <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      state      <= IDLE;
      dir        <= 2'd0;
      win_hit    <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (mv.move_valid && mv.move_ready) begin
          if (legal) begin
            board[BW'(2*(int'(mv.move_row)*N + int'(mv.move_col))) +: 2] <= turn;
            move_count <= move_count + 1'b1;
            r_q        <= mv.move_row;
            c_q        <= mv.move_col;
            player     <= turn;
            dir        <= 2'd0;
            state      <= SCAN;
          end else
            err <= 1'b1;
        end
        SCAN: begin
          win_hit <= win_hit | hit;
          dir     <= dir + 2'd1;
          if (dir == 2'd3) begin
            state <= RESOLVE;
            ack   <= 1'b1;
          end
        end
        RESOLVE: begin
          if (win_hit) begin
            winner    <= player;
            game_over <= 1'b1;
          end else if (move_count == MW'(N*N)) begin
            winner    <= 2'd3;
            game_over <= 1'b1;
          end else
            turn <= (turn == 2'd1) ? 2'd2 : 2'd1;
          win_hit <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
